// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and status generator for a dual-clock FIFO (read clock domain only).
// Latency: 1 rd_clk cycle from rd_en / wr_ptr_sync to every registered status output.
// Backpressure: reads while empty are dropped; rd_underflow pulses for one cycle.
//
// Ports:
//   rd_clk, rd_rst    read clock, synchronous active-high reset
//   rd_en             read request from the FIFO consumer
//   wr_ptr_sync       Gray write pointer, already synchronized into rd_clk
//   rd_addr           RAM read address (low bits of the binary read pointer)
//   rd_ptr            registered Gray read pointer, sent to the write domain
//   rd_empty          registered empty flag
//   rd_almost_empty   registered, occupancy <= ALMOST_EMPTY_TH
//   rd_count          registered occupancy as seen from the read domain
//   rd_underflow      one-cycle pulse after a read request while empty
module fifo_rd_ptr_empty #(
  parameter int add_size        = 8,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_en,
  input  logic [add_size:0]   wr_ptr_sync,
  output logic [add_size-1:0] rd_addr,
  output logic [add_size:0]   rd_ptr,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic [add_size:0]   rd_count,
  output logic                rd_underflow
);

  localparam logic [add_size:0] AE_TH = ALMOST_EMPTY_TH[add_size:0];

  logic [add_size:0] rd_bin;
  logic [add_size:0] rd_bin_next;
  logic [add_size:0] rd_gray_next;
  logic [add_size:0] wr_bin_sync;
  logic [add_size:0] count_next;
  logic              rd_inc;

  // A read is accepted only while the registered empty flag is low.
  assign rd_inc       = rd_en & ~rd_empty;
  assign rd_bin_next  = rd_bin + {{add_size{1'b0}}, rd_inc};
  assign rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i <= add_size; i++) begin
      wr_bin_sync[i] = ^(wr_ptr_sync >> i);
    end
  end

  // Modulo subtraction; the extra pointer bit distinguishes full from empty.
  assign count_next = wr_bin_sync - rd_bin_next;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin          <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_count        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      rd_bin          <= rd_bin_next;
      rd_ptr          <= rd_gray_next;
      // Comparing against the next Gray pointer lets the read that takes the
      // last word raise empty on the same edge that moves the pointer.
      rd_empty        <= (rd_gray_next == wr_ptr_sync);
      rd_almost_empty <= (count_next <= AE_TH);
      rd_count        <= count_next;
      rd_underflow    <= rd_en & rd_empty;
    end
  end

  assign rd_addr = rd_bin[add_size-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
module tb_fifo_rd_ptr_empty;

  logic       rd_clk;
  logic       rd_rst;
  logic       rd_en;
  logic [8:0] wr_ptr_sync;
  logic [7:0] rd_addr;
  logic [8:0] rd_ptr;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [8:0] rd_count;
  logic       rd_underflow;

  fifo_rd_ptr_empty #(.add_size(8), .ALMOST_EMPTY_TH(4)) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rd_en(rd_en),
    .wr_ptr_sync(wr_ptr_sync),
    .rd_addr(rd_addr),
    .rd_ptr(rd_ptr),
    .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty),
    .rd_count(rd_count),
    .rd_underflow(rd_underflow)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: words written (m_wr) and words read (m_rd), both mod 512.
  int m_wr = 0;
  int m_rd = 0;
  int m_count = 0;
  bit m_empty = 1;
  bit m_uf = 0;

  function automatic logic [8:0] to_gray(input int b);
    logic [8:0] v;
    v = b[8:0];
    return v ^ (v >> 1);
  endfunction

  // Apply one clock of stimulus and advance the reference model; no checking.
  task automatic cycle(input bit rst, input bit en);
    bit accept;
    rd_rst      = rst;
    rd_en       = en;
    wr_ptr_sync = to_gray(m_wr);
    @(posedge rd_clk);
    if (rst) begin
      m_rd = 0; m_count = 0; m_empty = 1; m_uf = 0;
    end else begin
      accept  = en && !m_empty;
      m_uf    = en && m_empty;
      m_rd    = (m_rd + (accept ? 1 : 0)) & 511;
      m_count = (m_wr - m_rd) & 511;
      m_empty = (m_count == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    m_wr = 3;  // wr_ptr_sync = 9'h002
    for (int k = 0; k < 2; k++) begin
      cycle(1, 1);
      n_total++;
      if ({rd_empty, rd_almost_empty, rd_count, rd_ptr, rd_underflow, rd_addr} !== {1'b1, 1'b1, 9'd0, 9'd0, 1'b0, 8'd0})
        $display("FAIL reset cyc%0d: empty=%b ae=%b count=%0d ptr=%h uf=%b addr=%0d, want 1 1 0 000 0 0",
                 k, rd_empty, rd_almost_empty, rd_count, rd_ptr, rd_underflow, rd_addr);
      else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    logic [8:0] ptrs [3];
    ptrs[0] = 9'h001; ptrs[1] = 9'h003; ptrs[2] = 9'h002;
    cycle(0, 0);
    n_total++;
    if ({rd_empty, rd_count, rd_almost_empty, rd_addr} !== {1'b0, 9'd3, 1'b1, 8'd0})
      $display("FAIL fill: empty=%b count=%0d ae=%b addr=%0d, want 0 3 1 0", rd_empty, rd_count, rd_almost_empty, rd_addr);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1);
      n_total++;
      if (rd_addr !== 8'(k + 1) || rd_ptr !== ptrs[k] || rd_count !== 9'(2 - k) || rd_empty !== (k == 2))
        $display("FAIL drain%0d: addr=%0d ptr=%h count=%0d empty=%b, want %0d %h %0d %b",
                 k, rd_addr, rd_ptr, rd_count, rd_empty, k + 1, ptrs[k], 2 - k, (k == 2));
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    logic [7:0] addr0;
    logic [8:0] ptr0;
    addr0 = rd_addr;
    ptr0  = rd_ptr;
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1);
      n_total++;
      if (rd_underflow !== 1'b1 || rd_addr !== addr0 || rd_ptr !== ptr0 || rd_empty !== 1'b1)
        $display("FAIL underflow%0d: uf=%b addr=%0d ptr=%h empty=%b, want 1 %0d %h 1",
                 k, rd_underflow, rd_addr, rd_ptr, rd_empty, addr0, ptr0);
      else n_pass++;
    end
    cycle(0, 0);
    n_total++;
    if (rd_underflow !== 1'b0) $display("FAIL underflow_clear: uf=%b want 0", rd_underflow);
    else n_pass++;
  endtask

  task automatic test_full_and_wrap();
    m_wr = 0;
    cycle(1, 0);
    m_wr = 256;  // wr_ptr_sync = 9'h180
    cycle(0, 0);
    n_total++;
    if (rd_count !== 9'd256 || rd_almost_empty !== 1'b0 || rd_empty !== 1'b0)
      $display("FAIL full: count=%0d ae=%b empty=%b, want 256 0 0", rd_count, rd_almost_empty, rd_empty);
    else n_pass++;
    for (int k = 1; k <= 252; k++) begin
      cycle(0, 1);
      n_total++;
      if (rd_count !== 9'(256 - k) || rd_almost_empty !== (k >= 252))
        $display("FAIL almost_empty k=%0d: count=%0d ae=%b, want %0d %b",
                 k, rd_count, rd_almost_empty, 256 - k, (k >= 252));
      else n_pass++;
    end
    m_wr = 508;
    for (int k = 0; k < 256; k++) cycle(0, 1);
    n_total++;
    if (rd_empty !== 1'b1 || rd_count !== 9'd0 || rd_addr !== 8'd252)
      $display("FAIL drain508: empty=%b count=%0d addr=%0d, want 1 0 252", rd_empty, rd_count, rd_addr);
    else n_pass++;
    m_wr = 1;  // Gray(1) = 9'h001, writer has wrapped
    cycle(0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1);
    n_total++;
    if (rd_ptr !== 9'h100 || rd_count !== 9'd2 || rd_addr !== 8'd255)
      $display("FAIL pre_wrap: ptr=%h count=%0d addr=%0d, want 100 2 255", rd_ptr, rd_count, rd_addr);
    else n_pass++;
    cycle(0, 1);
    n_total++;
    if (rd_ptr !== 9'h000 || rd_addr !== 8'd0 || rd_count !== 9'd1 || rd_empty !== 1'b0)
      $display("FAIL wrap: ptr=%h addr=%0d count=%0d empty=%b, want 000 0 1 0", rd_ptr, rd_addr, rd_count, rd_empty);
    else n_pass++;
    cycle(0, 1);
    n_total++;
    if (rd_empty !== 1'b1 || rd_count !== 9'd0)
      $display("FAIL wrap_empty: empty=%b count=%0d, want 1 0", rd_empty, rd_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    m_wr = 0;
    cycle(1, 0);
    m_wr = 1;
    cycle(0, 0);
    m_wr = 2;  // write arrives on the same edge as the read
    cycle(0, 1);
    n_total++;
    if (rd_empty !== 1'b0 || rd_count !== 9'd1 || rd_addr !== 8'd1)
      $display("FAIL simultaneous: empty=%b count=%0d addr=%0d, want 0 1 1", rd_empty, rd_count, rd_addr);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    m_wr = 0;
    cycle(1, 0);
    m_wr = 10;
    cycle(0, 0);
    cycle(0, 1);
    cycle(0, 1);
    cycle(1, 1);
    n_total++;
    if ({rd_empty, rd_almost_empty, rd_count, rd_ptr, rd_underflow, rd_addr} !== {1'b1, 1'b1, 9'd0, 9'd0, 1'b0, 8'd0})
      $display("FAIL mid_reset: empty=%b ae=%b count=%0d ptr=%h uf=%b addr=%0d, want 1 1 0 000 0 0",
               rd_empty, rd_almost_empty, rd_count, rd_ptr, rd_underflow, rd_addr);
    else n_pass++;
    cycle(0, 0);
    n_total++;
    if (rd_count !== 9'd10 || rd_empty !== 1'b0)
      $display("FAIL post_reset: count=%0d empty=%b, want 10 0", rd_count, rd_empty);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [29:0] got, want;
    bit rst, en;
    int wr_bias;
    m_wr = 0;
    cycle(1, 0);
    for (int k = 0; k < 4000; k++) begin
      wr_bias = ((k / 500) % 2 == 0) ? 70 : 30;  // alternate filling and draining phases
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 99) < 50);
      if (rst) m_wr = 0;
      else if ($urandom_range(0, 99) < wr_bias && (((m_wr + 1 - m_rd) & 511) <= 256))
        m_wr = (m_wr + 1) & 511;
      cycle(rst, en);
      got  = {rd_empty, rd_almost_empty, rd_count, rd_ptr, rd_underflow, rd_addr};
      want = {m_empty, (m_count <= 4), m_count[8:0], to_gray(m_rd), m_uf, m_rd[7:0]};
      n_total++;
      if (got !== want)
        $display("FAIL random k=%0d: got empty/ae/count/ptr/uf/addr=%h, want %h", k, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    rd_rst = 1'b1;
    rd_en = 1'b0;
    wr_ptr_sync = '0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_full_and_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
